// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: FSM state
// encoding, the hard-wired zero register and default widths.
package mips_pipe_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int STAT_WIDTH     = 32;

  // $zero never carries a real dependency, so it can never cause a stall.
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef enum logic {
    RUN       = 1'b0,
    MULT_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags when the instruction in ID reads a
// register that the load currently in EX has not yet written back.
// Purely combinational so the forwarding unit can reuse it.
module load_use_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = mips_pipe_pkg::REG_ADDR_WIDTH
) (
  input  logic                      mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      uses_rt,
  output logic                      hazard
);

  logic [REG_ADDR_WIDTH-1:0] zero_reg;
  logic                      rs_match;
  logic                      rt_match;

  assign zero_reg = REG_ADDR_WIDTH'(REG_ZERO);

  // rs is always read; rt only matters when the ID instruction uses it.
  always_comb begin
    rs_match = (ex_rt == id_rs);
    rt_match = uses_rt && (ex_rt == id_rt);
    hazard   = mem_read && (ex_rt != zero_reg) && (rs_match || rt_match);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Front-end hazard and stall controller for the 5-stage MIPS pipeline.
// Drives the PC / IF-ID / ID-EX enables every cycle from the current
// state and hazard inputs, and counts cycles in which the PC is held.
//
// Control handshake: outputs are combinational and are consumed by the
// pipeline registers on the same rising edge. pc_write=1 means the PC
// loads; if_id_write=1 captures fetch data, if_id_flush=1 loads a NOP
// (never both); id_ex_flush=1 replaces the ID instruction with a bubble.
// busy is the registered FSM state (1 = MULT_WAIT) and doubles as the
// state observation point.
module hazard_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = mips_pipe_pkg::REG_ADDR_WIDTH,
  parameter int MULT_CYCLES    = 4,
  parameter int STAT_WIDTH     = mips_pipe_pkg::STAT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rt,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
  input  logic                      branch_taken,
  input  logic                      mult_start,
  input  logic                      imem_ready,
  input  logic                      stat_clear,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      busy,
  output logic [STAT_WIDTH-1:0]     stall_cycles
);

  localparam int CNT_W = $clog2(MULT_CYCLES);
  // The RUN cycle that sees mult_start is the first stall cycle, so the
  // wait state covers the remaining MULT_CYCLES-1 cycles (cnt down to 0).
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_use;

  load_use_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_load_use_detect (
    .mem_read (ex_mem_read),
    .ex_rt    (ex_rt),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .uses_rt  (id_uses_rt),
    .hazard   (load_use)
  );

  // Output decode: reset forces everything off, MULT_WAIT holds the front
  // end, RUN applies branch > mult > load-use > imem wait > advance.
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!reset) begin
      if (state == MULT_WAIT) begin
        id_ex_flush = 1'b1;
      end else if (branch_taken) begin
        pc_write    = 1'b1;
        if_id_flush = 1'b1;
      end else if (mult_start || load_use) begin
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        // Fetch not valid: keep PC, feed a NOP; ID proceeds normally.
        if_id_flush = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  // FSM and wait counter; a taken branch suppresses entry into MULT_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!branch_taken && mult_start) begin
            state <= MULT_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        MULT_WAIT: begin
          if (cnt == '0) begin
            state <= RUN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == MULT_WAIT);

  // Saturating count of cycles with the PC held; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stat_clear) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Each step drives one cycle of
// inputs and queues the hand-computed response for that cycle; a monitor
// on the falling edge pops and compares control outputs, busy and the
// stall counter.
module tb_hazard_stall_ctrl;

  localparam int RW  = 5;
  localparam int MC  = 4;
  localparam int SW  = 4;
  localparam int W   = 4 + 1 + SW;

  logic          clk;
  logic          reset;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_uses_rt;
  logic          ex_mem_read;
  logic [RW-1:0] ex_rt;
  logic          branch_taken;
  logic          mult_start;
  logic          imem_ready;
  logic          stat_clear;
  logic          pc_write;
  logic          if_id_write;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          busy;
  logic [SW-1:0] stall_cycles;

  logic [W-1:0]  exp_q[$];
  int            total;
  int            bad;
  bit            done;

  hazard_stall_ctrl #(
    .REG_ADDR_WIDTH (RW),
    .MULT_CYCLES    (MC),
    .STAT_WIDTH     (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .mult_start   (mult_start),
    .imem_ready   (imem_ready),
    .stat_clear   (stat_clear),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  // Clock and initial reset level.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: apply one cycle of inputs just after the rising edge and queue
  // the expected {pc_write, if_id_write, if_id_flush, id_ex_flush}, busy and
  // stall_cycles for that cycle, then wait for the next rising edge.
  task automatic step(input logic rst, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                      input logic urt, input logic mrd, input logic [RW-1:0] ert,
                      input logic br, input logic ms, input logic rdy, input logic clr,
                      input logic [3:0] e_ctrl, input logic e_busy, input logic [SW-1:0] e_stall);
    reset        = rst;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    ex_mem_read  = mrd;
    ex_rt        = ert;
    branch_taken = br;
    mult_start   = ms;
    imem_ready   = rdy;
    stat_clear   = clr;
    exp_q.push_back({e_ctrl, e_busy, e_stall});
    @(posedge clk);
    #1;
  endtask

  // Shorthand for a cycle with no hazard sources active.
  task automatic idle(input logic [3:0] e_ctrl, input logic e_busy, input logic [SW-1:0] e_stall);
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, e_ctrl, e_busy, e_stall);
  endtask

  // Monitor: the control vector is presented every cycle, so pop and check
  // one expectation on every falling edge that has one pending.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== e[W-1 -: 4]) begin
          bad++;
          $display("FAIL ctrl t=%0t got=%b want=%b (pc,ifw,iff,exf)", $time,
                   {pc_write, if_id_write, if_id_flush, id_ex_flush}, e[W-1 -: 4]);
        end
        total++;
        if (busy !== e[SW]) begin
          bad++;
          $display("FAIL busy t=%0t got=%b want=%b", $time, busy, e[SW]);
        end
        total++;
        if (stall_cycles !== e[SW-1:0]) begin
          bad++;
          $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time, stall_cycles, e[SW-1:0]);
        end
      end
    end
  end

  // Directed sequence with hand-computed responses (MULT_CYCLES=4).
  initial begin
    int wait_cnt;
    total = 0;
    bad   = 0;
    done  = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Reset: all controls forced low, counters cleared.
    step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0);
    idle(4'b1100, 1'b0, 4'd0);
    // Load-use on rs: one bubble cycle.
    step(1'b0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 4'd0);
    idle(4'b1100, 1'b0, 4'd1);
    // Load into $zero is never a hazard.
    step(1'b0, 5'd0, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 1'b0, 4'd1);
    // rt match only counts when rt is used.
    step(1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 1'b0, 4'd1);
    step(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 4'd1);
    idle(4'b1100, 1'b0, 4'd2);
    // mult: 1 RUN cycle + 3 MULT_WAIT cycles; branch mid-wait ignored.
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 4'd2);
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 4'd3);
    idle(4'b0001, 1'b1, 4'd4);
    idle(4'b0001, 1'b1, 4'd5);
    idle(4'b1100, 1'b0, 4'd6);
    // Branch beats load-use and mult: no bubble, no wait, no stall count.
    step(1'b0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, 1'b0, 4'd6);
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010, 1'b0, 4'd6);
    idle(4'b1100, 1'b0, 4'd6);
    // imem wait for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 4'(6 + i));
    end
    idle(4'b1100, 1'b0, 4'd9);
    // stat_clear, also winning over a same-cycle stall.
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b0, 4'd9);
    idle(4'b1100, 1'b0, 4'd0);
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 4'd0);
    idle(4'b1100, 1'b0, 4'd0);
    // Reset on the 2nd MULT_WAIT cycle aborts the stall at once.
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 4'd0);
    idle(4'b0001, 1'b1, 4'd1);
    step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0);
    idle(4'b1100, 1'b0, 4'd0);
    idle(4'b1100, 1'b0, 4'd0);
    // Long imem wait drives the 4-bit counter into saturation at 15.
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0,
           (i > 15) ? 4'd15 : 4'(i));
    end
    idle(4'b1100, 1'b0, 4'd15);
    // Drain: every queued expectation must be consumed within a few cycles.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Front-end hazard and stall controller for the 5-stage MIPS pipeline. It decides every cycle whether the PC advances, whether the IF/ID register captures, holds or is flushed, and whether a bubble is injected into ID/EX. It handles taken-branch flushes, load-use stalls, instruction-memory wait states and multi-cycle multiply/divide stalls. It sits between the hazard sources (ID decode, EX stage, instruction memory) and the `pc_write` / `if_id_write` / `flush` enables of the PC register and the IF/ID and ID/EX pipeline registers.

## Interface
- `REG_ADDR_WIDTH`, default 5: register specifier width.
- `MULT_CYCLES`, default 4: total front-end stall cycles for a mult/div, start cycle included. Must be ≥ 2.
- `STAT_WIDTH`, default 32: width of the stall statistics counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `id_rs`, `id_rt` in REG_ADDR_WIDTH: source registers of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_rt` in REG_ADDR_WIDTH: load destination in EX.
- `branch_taken` in 1: a branch resolved in ID is taken this cycle.
- `mult_start` in 1: a mult/div enters EX this cycle.
- `imem_ready` in 1: the fetch data on the IF/ID input is valid this cycle.
- `stat_clear` in 1: synchronous clear of `stall_cycles`.
- `pc_write` out 1: PC register load enable.
- `if_id_write` out 1: IF/ID load enable.
- `if_id_flush` out 1: zero IF/ID (NOP).
- `id_ex_flush` out 1: inject a bubble into ID/EX.
- `busy` out 1: FSM is in MULT_WAIT.
- `stall_cycles` out STAT_WIDTH: count of cycles with `pc_write`=0.

## Operation
- FSM states: RUN, MULT_WAIT. Down-counter `cnt` has width $clog2(MULT_CYCLES).
- Load-use hazard: `ex_mem_read` && `ex_rt`≠0 && (`ex_rt`==`id_rs` || (`id_uses_rt` && `ex_rt`==`id_rt`)).
- In RUN, the first matching condition applies, in this priority order:
  1. `branch_taken`: `pc_write`=1, `if_id_flush`=1, `if_id_write`=0, `id_ex_flush`=0.
  2. `mult_start`: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1. Next state is MULT_WAIT with `cnt`←MULT_CYCLES−2.
  3. Load-use hazard: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1. State stays RUN.
  4. `!imem_ready`: `pc_write`=0, `if_id_write`=0, `if_id_flush`=1, `id_ex_flush`=0. The ID instruction proceeds normally.
  5. Otherwise: `pc_write`=1, `if_id_write`=1, both flushes 0.
- In MULT_WAIT: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `if_id_flush`=0, `busy`=1.
  - All of `branch_taken`, `mult_start`, hazard inputs and `imem_ready` are ignored.
  - If `cnt`==0, next state is RUN; otherwise `cnt` decrements.
- `if_id_flush` and `if_id_write` are never both 1.
- `stall_cycles` increments on every edge where `pc_write`=0. It saturates at all-ones. `stat_clear` takes precedence over the increment.

## Timing
- Control outputs are combinational from the current state and inputs, for same-cycle use by the pipeline registers. `busy` and `stall_cycles` are registered.
- Reset (asynchronous assertion): state RUN, `cnt`=0, `stall_cycles`=0, `busy`=0. While `reset`=1, `pc_write`, `if_id_write`, `if_id_flush` and `id_ex_flush` are forced to 0.
- Reset asserted mid-MULT_WAIT aborts the stall immediately. RUN behaviour resumes on the first edge after deassertion.
- A load-use stall lasts exactly 1 cycle, provided EX receives the bubble.
- A mult/div stall lasts exactly MULT_CYCLES cycles: 1 in RUN plus MULT_CYCLES−1 in MULT_WAIT.
- A branch flush lasts 1 cycle. `imem_ready` low stalls for as long as it stays low.
- `branch_taken` together with `mult_start` or a load-use hazard: the branch wins. No bubble is injected and no MULT_WAIT is entered.

## Structure
- Shared package `mips_pipe_pkg` holds:
  - the state enum (RUN=0, MULT_WAIT=1);
  - the `REG_ZERO` constant;
  - default widths `REG_ADDR_WIDTH` and `STAT_WIDTH`.
- One sub-module, `load_use_detect`: combinational comparator producing the hazard bit, reused by the forwarding unit.
- The top module holds the FSM, `cnt`, the output decode and the statistics counter.

## Test plan
- `id_rs`=5, `ex_rt`=5, `ex_mem_read`=1 for 1 cycle → one cycle of `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1; then `pc_write`=1. `stall_cycles`=1. Repeat with `ex_rt`=0 → no stall.
- `id_rt`=7, `ex_rt`=7, `ex_mem_read`=1: with `id_uses_rt`=0 → no stall; with `id_uses_rt`=1 → 1-cycle stall.
- `mult_start` pulse with MULT_CYCLES=4 → `pc_write`=0 for exactly 4 cycles; `busy`=1 for 3 cycles; `branch_taken` asserted mid-wait is ignored; `stall_cycles`=4.
- `branch_taken`=1 together with a load-use hazard → `if_id_flush`=1, `pc_write`=1, `id_ex_flush`=0; `stall_cycles` unchanged.
- `imem_ready` low for 3 cycles → 3 cycles of `if_id_flush`=1 and `pc_write`=0; `stall_cycles`=3; `stat_clear` → 0.
- `reset` asserted on the 2nd cycle of MULT_WAIT → `busy`=0 and all control outputs 0 immediately. After release, the first cycle is a normal RUN advance.
